// File: rtl/d_latch.sv
// -----------------------------------------------------------------------------
// d_latch
//
// Clocked model of a gated SR latch with complementary outputs. S sets and R
// resets the stored bit, but only on clock edges where gate C is high. The
// forbidden request S=R=1 drives both outputs low, as a NOR latch would, and
// raises `illegal`. The pair stays there until a later gated cycle asks for
// something else.
//
// Optional feature (compile-time macro DLATCH_ILLEGAL_CNT_EN):
//   When the macro is defined, the block adds parameter CNT_W and output port
//   illegal_cnt. illegal_cnt is a saturating count of entries into the
//   forbidden state. When the macro is undefined, the counter and the port are
//   both absent.
//
// Ports:
//   clk          in   sole clock; all state updates on its rising edge
//   rst          in   asynchronous, active-high reset
//   S            in   set request (sampled only while C=1)
//   R            in   reset request (sampled only while C=1)
//   C            in   gate/enable
//   Q            out  stored bit (registered)
//   Q_n          out  complement bit (registered); 0 together with Q when the
//                     latch is in the forbidden state
//   illegal      out  high while {Q,Q_n} == 2'b00 (registered)
//   illegal_cnt  out  [CNT_W] saturating forbidden-entry count (macro only)
// -----------------------------------------------------------------------------
module d_latch
`ifdef DLATCH_ILLEGAL_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic             R,
    input  logic             C,
    output logic             Q,
    output logic             Q_n,
    output logic             illegal
`ifdef DLATCH_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    logic q_r;
    logic q_n_r;
    logic illegal_r;
    logic q_next_s;
    logic q_n_next_s;
    logic illegal_next_s;
    logic forbidden_now_s;

    assign forbidden_now_s = ~q_r & ~q_n_r;

    // Next-state decode of the latch pair from the gated {S,R} request
    always_comb begin
        q_next_s   = q_r;
        q_n_next_s = q_n_r;
        if (C) begin
            case ({S, R})
                2'b00: begin
                    // A plain hold would keep the forbidden state forever, so
                    // a quiet gated cycle resolves it to the reset value
                    if (forbidden_now_s) begin
                        q_next_s   = 1'b0;
                        q_n_next_s = 1'b1;
                    end else begin
                        q_next_s   = q_r;
                        q_n_next_s = q_n_r;
                    end
                end
                2'b10: begin
                    q_next_s   = 1'b1;
                    q_n_next_s = 1'b0;
                end
                2'b01: begin
                    q_next_s   = 1'b0;
                    q_n_next_s = 1'b1;
                end
                2'b11: begin
                    q_next_s   = 1'b0;
                    q_n_next_s = 1'b0;
                end
                default: begin
                    q_next_s   = q_r;
                    q_n_next_s = q_n_r;
                end
            endcase
        end else begin
            q_next_s   = q_r;
            q_n_next_s = q_n_r;
        end
    end

    assign illegal_next_s = ~q_next_s & ~q_n_next_s;

    // Latch pair and illegal flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r       <= 1'b0;
            q_n_r     <= 1'b1;
            illegal_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            q_n_r     <= q_n_next_s;
            illegal_r <= illegal_next_s;
        end
    end

    assign Q       = q_r;
    assign Q_n     = q_n_r;
    assign illegal = illegal_r;

`ifdef DLATCH_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             enter_forbidden_s;

    // Only the legal-to-forbidden transition counts; staying in the state does not
    assign enter_forbidden_s = illegal_next_s & ~illegal_r;

    // Saturating count of forbidden-state entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enter_forbidden_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign illegal_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_d_latch.sv
// -----------------------------------------------------------------------------
// tb_d_latch: self-checking bench for d_latch.
// Inputs change on the falling edge. Outputs are compared on the next falling
// edge against a rule-level model of the gated SR latch.
// -----------------------------------------------------------------------------
module tb_d_latch;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic rst;
    logic S;
    logic R;
    logic C;
    logic Q;
    logic Q_n;
    logic illegal;
`ifdef DLATCH_ILLEGAL_CNT_EN
    logic [TB_CNT_W-1:0] illegal_cnt;
`endif

    int checks;
    int errors;

    // Reference model: the stored value is one of three abstract conditions
    typedef enum int { M_ZERO, M_ONE, M_FORBID } mstate_t;
    mstate_t m_state;
    int      m_cnt;
    int      m_cnt_max;

`ifdef DLATCH_ILLEGAL_CNT_EN
    d_latch #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .S(S), .R(R), .C(C),
        .Q(Q), .Q_n(Q_n), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );
`else
    d_latch dut (
        .clk(clk), .rst(rst), .S(S), .R(R), .C(C),
        .Q(Q), .Q_n(Q_n), .illegal(illegal)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_outs();
        case (m_state)
            M_ONE:    return 3'b100;
            M_FORBID: return 3'b001;
            default:  return 3'b010;
        endcase
    endfunction

    function automatic int observed_cnt();
`ifdef DLATCH_ILLEGAL_CNT_EN
        return int'(illegal_cnt);
`else
        return m_cnt;
`endif
    endfunction

    task automatic model_reset();
        m_state = M_ZERO;
        m_cnt   = 0;
    endtask

    // Apply one gated request to the model, using the latch rules directly
    task automatic model_step(input logic s, input logic r, input logic c);
        mstate_t prev;
        prev = m_state;
        if (c) begin
            if (s && r)  m_state = M_FORBID;
            else if (s)  m_state = M_ONE;
            else if (r)  m_state = M_ZERO;
            else if (m_state == M_FORBID) m_state = M_ZERO;
        end
        if (m_state == M_FORBID && prev != M_FORBID && m_cnt < m_cnt_max)
            m_cnt = m_cnt + 1;
    endtask

    // At a falling edge: drive inputs, let one rising edge pass, return at the next falling edge
    task automatic tick(input logic s, input logic r, input logic c);
        S = s; R = r; C = c;
        @(posedge clk);
        model_step(s, r, c);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        S = 1'b0; R = 1'b0; C = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Q, Q_n, illegal} !== 3'b010) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 010", {Q, Q_n, illegal});
        end
`ifdef DLATCH_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if ({Q, Q_n, illegal} !== 3'b010) begin
                errors++;
                $display("FAIL gate_closed[%0d]: got %b expected 010", i, {Q, Q_n, illegal});
            end
        end
    endtask

    task automatic test_set_hold_reset();
        logic [1:0] sr_seq [4];
        logic [2:0] want   [4];
        sr_seq = '{2'b10, 2'b00, 2'b01, 2'b00};
        want   = '{3'b100, 3'b100, 3'b010, 3'b010};
        for (int i = 0; i < 4; i++) begin
            tick(sr_seq[i][1], sr_seq[i][0], 1'b1);
            checks++;
            if ({Q, Q_n, illegal} !== want[i] || exp_outs() !== want[i]) begin
                errors++;
                $display("FAIL set_hold_reset[%0d]: got %b expected %b", i, {Q, Q_n, illegal}, want[i]);
            end
        end
    endtask

    task automatic test_forbidden();
        int cnt_before;
        cnt_before = observed_cnt();
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if ({Q, Q_n, illegal} !== 3'b001) begin
            errors++;
            $display("FAIL forbid_enter: got %b expected 001", {Q, Q_n, illegal});
        end
        checks++;
        if (observed_cnt() != cnt_before + 1 || m_cnt != cnt_before + 1) begin
            errors++;
            $display("FAIL forbid_cnt: got %0d expected %0d", observed_cnt(), cnt_before + 1);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if ({Q, Q_n, illegal} !== 3'b010) begin
            errors++;
            $display("FAIL forbid_release: got %b expected 010", {Q, Q_n, illegal});
        end
    endtask

    task automatic test_persistence();
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if ({Q, Q_n, illegal} !== 3'b001) begin
                errors++;
                $display("FAIL persist[%0d]: got %b expected 001", i, {Q, Q_n, illegal});
            end
        end
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if ({Q, Q_n, illegal} !== 3'b100) begin
            errors++;
            $display("FAIL persist_exit_set: got %b expected 100", {Q, Q_n, illegal});
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got Q=%b expected 1", Q);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Q, Q_n, illegal} !== 3'b010) begin
            errors++;
            $display("FAIL async_rst: got %b expected 010", {Q, Q_n, illegal});
        end
`ifdef DLATCH_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== '0) begin
            errors++;
            $display("FAIL async_rst_cnt: got %0d expected 0", illegal_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int want_cnt [5];
        want_cnt = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            checks++;
            if ({Q, Q_n, illegal} !== 3'b001) begin
                errors++;
                $display("FAIL sat_outs[%0d]: got %b expected 001", i, {Q, Q_n, illegal});
            end
`ifdef DLATCH_ILLEGAL_CNT_EN
            checks++;
            if (int'(illegal_cnt) != want_cnt[i]) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, illegal_cnt, want_cnt[i]);
            end
`endif
            tick(1'b0, 1'b0, 1'b1);
        end
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (illegal !== 1'b1 || observed_cnt() != 1) begin
            errors++;
            $display("FAIL hold_forbid: got illegal=%b cnt=%0d expected illegal=1 cnt=1", illegal, observed_cnt());
        end
    endtask

    task automatic test_random();
        logic s, r, c;
        for (int i = 0; i < 400; i++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) != 0);
            tick(s, r, c);
            checks++;
            if ({Q, Q_n, illegal} !== exp_outs()) begin
                errors++;
                $display("FAIL rand_outs[%0d]: got %b expected %b", i, {Q, Q_n, illegal}, exp_outs());
            end
`ifdef DLATCH_ILLEGAL_CNT_EN
            checks++;
            if (int'(illegal_cnt) != m_cnt) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, illegal_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_cnt_max = (1 << TB_CNT_W) - 1;
        rst = 1'b0; S = 1'b0; R = 1'b0; C = 1'b0;
        model_reset();
        test_reset();
        test_set_hold_reset();
        test_forbidden();
        test_persistence();
        test_async_reset();
        test_saturation();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
